// File: rtl/dram_ctrl_pkg.sv
// Shared types and helpers for the DRAM burst read/write controllers.
// Burst stride and burst length are derived from data width and burst log.
package dram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_BURST,
    ST_DONE_WAIT
  } state_e;

  function automatic longint unsigned access_stride(
    input int unsigned dw,
    input int unsigned mbl
  );
    return 64'(dw / 8) << mbl;
  endfunction

  function automatic int unsigned maxburst_num(
    input int unsigned mbl
  );
    return 1 << mbl;
  endfunction

endpackage

// File: rtl/dram_wr_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; RST flushes it.
// Caller never pushes when full nor pops when empty.
module dram_wr_fifo #(
  parameter int DW = 512,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic [AW:0]   count,
  output logic          full
);
  localparam int CW = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wp_d  = wp_q + AW'(push);
    rp_d  = rp_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= din;
  end

  assign head  = mem[rp_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/dram_write_ctrl.sv
// Avalon-MM burst write master: buffers user words, issues full bursts.
// Define DRAM_WRITE_ACKWAIT_EN to hold WRITE_RDY low until all acks return.
module dram_write_ctrl #(
  parameter int MAXBURST_LOG   = 4,
  parameter int WRITENUM_SIZE  = 31,
  parameter int DRAM_ADDRSPACE = 64,
  parameter int DRAM_DATAWIDTH = 512,
  parameter int FIFO_DEPTH_LOG = 5
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          WRITE_REQ,
  input  logic [DRAM_ADDRSPACE-1:0]     WRITE_INITADDR,
  input  logic [WRITENUM_SIZE:0]        WRITE_NUM,
  input  logic [DRAM_DATAWIDTH-1:0]     WRITE_DATA,
  input  logic                          WRITE_DATAEN,
  output logic                          WRITE_DATA_RDY,
  output logic                          WRITE_RDY,
  input  logic                          AVALON_MM_WAITREQUEST,
  input  logic                          AVALON_MM_WRITEACK,
  input  logic [DRAM_DATAWIDTH-1:0]     AVALON_MM_READDATA,
  input  logic                          AVALON_MM_READDATAVALID,
  output logic [DRAM_ADDRSPACE-1:0]     AVALON_MM_ADDRESS,
  output logic                          AVALON_MM_WRITE,
  output logic                          AVALON_MM_READ,
  output logic [DRAM_DATAWIDTH-1:0]     AVALON_MM_WRITEDATA,
  output logic [DRAM_DATAWIDTH/8-1:0]   AVALON_MM_BYTEENABLE,
  output logic [MAXBURST_LOG:0]         AVALON_MM_BURSTCOUNT
);
  import dram_ctrl_pkg::*;

  localparam int NW = WRITENUM_SIZE + 1;
  localparam int BW = MAXBURST_LOG + 1;
  localparam int CW = FIFO_DEPTH_LOG + 1;
  localparam int AW = DRAM_ADDRSPACE;
  localparam logic [AW-1:0] STRIDE =
    AW'(access_stride(DRAM_DATAWIDTH, MAXBURST_LOG));
  localparam logic [BW-1:0] MAXB = BW'(maxburst_num(MAXBURST_LOG));

  if (FIFO_DEPTH_LOG < MAXBURST_LOG + 1) begin : g_depth_chk
    $error("FIFO_DEPTH_LOG must be >= MAXBURST_LOG+1");
  end

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [NW-1:0] bnum_q, bnum_d;
  logic [NW-1:0] left_q, left_d;
  logic [BW-1:0] last_q, last_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          wr_q, wr_d;
`ifdef DRAM_WRITE_ACKWAIT_EN
  logic [NW-1:0] ack_q, ack_d;
  logic [NW-1:0] btot_q, btot_d;
`endif

  logic [DRAM_DATAWIDTH-1:0] head;
  logic [CW-1:0] fcount;
  logic          full, busy, rdy, push, beat;
  logic [BW-1:0] need, req_last;
  logic [NW-1:0] req_bnum;
  logic          unused_in;

  assign busy = (state_q != ST_IDLE);
  assign rdy  = busy & ~full & (left_q != '0);
  assign push = WRITE_DATAEN & rdy;
  assign beat = wr_q & ~AVALON_MM_WAITREQUEST;
  assign need = (bnum_q == NW'(1)) ? last_q : MAXB;

  // Partial tail burst rounds the burst count up.
  assign req_bnum = (WRITE_NUM >> MAXBURST_LOG)
                  + NW'(WRITE_NUM[MAXBURST_LOG-1:0] != '0);
  assign req_last = (WRITE_NUM[MAXBURST_LOG-1:0] == '0) ? MAXB
                  : {1'b0, WRITE_NUM[MAXBURST_LOG-1:0]};

  dram_wr_fifo #(
    .DW (DRAM_DATAWIDTH),
    .AW (FIFO_DEPTH_LOG)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (beat),
    .din   (WRITE_DATA),
    .head  (head),
    .count (fcount),
    .full  (full)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bnum_d  = bnum_q;
    left_d  = left_q - NW'(push);
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    beat_d  = beat_q;
    wr_d    = wr_q;
`ifdef DRAM_WRITE_ACKWAIT_EN
    ack_d   = ack_q + NW'(busy & AVALON_MM_WRITEACK);
    btot_d  = btot_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (WRITE_REQ && WRITE_NUM != '0) begin
          state_d = ST_FILL;
          addr_d  = WRITE_INITADDR;
          bnum_d  = req_bnum;
          last_d  = req_last;
          left_d  = WRITE_NUM;
`ifdef DRAM_WRITE_ACKWAIT_EN
          ack_d   = '0;
          btot_d  = req_bnum;
`endif
        end
      end
      ST_FILL: begin
        if (fcount >= CW'(need)) begin
          state_d = ST_BURST;
          wr_d    = 1'b1;
          bcnt_d  = need;
          beat_d  = '0;
        end
      end
      ST_BURST: begin
        if (beat) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == bcnt_q - BW'(1)) begin
            wr_d   = 1'b0;
            beat_d = '0;
            addr_d = addr_q + STRIDE;
            bnum_d = bnum_q - NW'(1);
            if (bnum_q == NW'(1)) begin
`ifdef DRAM_WRITE_ACKWAIT_EN
              state_d = ST_DONE_WAIT;
`else
              state_d = ST_IDLE;
`endif
            end else begin
              state_d = ST_FILL;
            end
          end
        end
      end
      ST_DONE_WAIT: begin
`ifdef DRAM_WRITE_ACKWAIT_EN
        if (ack_q >= btot_q) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      bnum_q  <= '0;
      left_q  <= '0;
      last_q  <= '0;
      bcnt_q  <= '0;
      beat_q  <= '0;
      wr_q    <= 1'b0;
`ifdef DRAM_WRITE_ACKWAIT_EN
      ack_q   <= '0;
      btot_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bnum_q  <= bnum_d;
      left_q  <= left_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      beat_q  <= beat_d;
      wr_q    <= wr_d;
`ifdef DRAM_WRITE_ACKWAIT_EN
      ack_q   <= ack_d;
      btot_q  <= btot_d;
`endif
    end
  end

`ifdef DRAM_WRITE_ACKWAIT_EN
  assign unused_in = ^{AVALON_MM_READDATA, AVALON_MM_READDATAVALID};
`else
  assign unused_in = ^{AVALON_MM_READDATA, AVALON_MM_READDATAVALID,
                       AVALON_MM_WRITEACK};
`endif

  assign WRITE_DATA_RDY       = rdy;
  assign WRITE_RDY            = ~busy;
  assign AVALON_MM_ADDRESS    = addr_q;
  assign AVALON_MM_WRITE      = wr_q;
  assign AVALON_MM_READ       = 1'b0;
  assign AVALON_MM_WRITEDATA  = head;
  assign AVALON_MM_BYTEENABLE = '1;
  assign AVALON_MM_BURSTCOUNT = bcnt_q;

endmodule

// File: tb/tb_dram_write_ctrl.sv
// Scoreboard bench for dram_write_ctrl: expected beats queued at push time.
// Bus monitor pops and compares each accepted beat; tasks check job-level behaviour.
module tb_dram_write_ctrl;

  typedef struct {
    logic [63:0]  addr;
    logic [4:0]   bc;
    logic [511:0] data;
  } beat_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         WRITE_REQ = 1'b0;
  logic [63:0]  WRITE_INITADDR = '0;
  logic [31:0]  WRITE_NUM = '0;
  logic [511:0] WRITE_DATA = '0;
  logic         WRITE_DATAEN = 1'b0;
  logic         WRITE_DATA_RDY;
  logic         WRITE_RDY;
  logic         AVALON_MM_WAITREQUEST = 1'b0;
  logic         AVALON_MM_WRITEACK = 1'b0;
  logic [511:0] AVALON_MM_READDATA = '0;
  logic         AVALON_MM_READDATAVALID = 1'b0;
  logic [63:0]  AVALON_MM_ADDRESS;
  logic         AVALON_MM_WRITE;
  logic         AVALON_MM_READ;
  logic [511:0] AVALON_MM_WRITEDATA;
  logic [63:0]  AVALON_MM_BYTEENABLE;
  logic [4:0]   AVALON_MM_BURSTCOUNT;

  dram_write_ctrl dut (
    .CLK                     (CLK),
    .RST                     (RST),
    .WRITE_REQ               (WRITE_REQ),
    .WRITE_INITADDR          (WRITE_INITADDR),
    .WRITE_NUM               (WRITE_NUM),
    .WRITE_DATA              (WRITE_DATA),
    .WRITE_DATAEN            (WRITE_DATAEN),
    .WRITE_DATA_RDY          (WRITE_DATA_RDY),
    .WRITE_RDY               (WRITE_RDY),
    .AVALON_MM_WAITREQUEST   (AVALON_MM_WAITREQUEST),
    .AVALON_MM_WRITEACK      (AVALON_MM_WRITEACK),
    .AVALON_MM_READDATA      (AVALON_MM_READDATA),
    .AVALON_MM_READDATAVALID (AVALON_MM_READDATAVALID),
    .AVALON_MM_ADDRESS       (AVALON_MM_ADDRESS),
    .AVALON_MM_WRITE         (AVALON_MM_WRITE),
    .AVALON_MM_READ          (AVALON_MM_READ),
    .AVALON_MM_WRITEDATA     (AVALON_MM_WRITEDATA),
    .AVALON_MM_BYTEENABLE    (AVALON_MM_BYTEENABLE),
    .AVALON_MM_BURSTCOUNT    (AVALON_MM_BURSTCOUNT)
  );

  beat_t exp_q[$];
  int    ack_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    pushed_total = 0;
  int    beats_total = 0;
  int    n_bursts = 0;
  int    acks_sent = 0;
  int    stall_checks = 0;
  bit    stall_en = 1'b0;

  logic [63:0] job_base;
  int          job_num;

  logic [63:0]  h_addr;
  logic [4:0]   h_bc;
  logic [511:0] h_data;
  bit           held = 1'b0;
  bit           started = 1'b0;
  int           bib = 0;

  initial forever #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    #1;
    AVALON_MM_WAITREQUEST = stall_en && ($urandom_range(0, 1) == 1);
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
    #1;
    if (ack_q.size() > 0 && ack_q[0] <= cyc) begin
      void'(ack_q.pop_front());
      AVALON_MM_WRITEACK = 1'b1;
      acks_sent++;
    end else begin
      AVALON_MM_WRITEACK = 1'b0;
    end
  end

  // Bus monitor: every accepted beat is checked against the scoreboard.
  initial forever begin
    beat_t e;
    @(negedge CLK);
    if (RST) begin
      bib = 0;
      started = 1'b0;
      held = 1'b0;
    end else if (AVALON_MM_WRITE) begin
      if (!started) begin
        started = 1'b1;
        n_bursts++;
        vectors++;
        if (pushed_total - beats_total < int'(AVALON_MM_BURSTCOUNT)) begin
          miscompares++;
          $display("FAIL burst_prefill: buffered %0d need %0d",
                   pushed_total - beats_total, AVALON_MM_BURSTCOUNT);
        end
      end
      if (held) begin
        vectors++;
        stall_checks++;
        if (AVALON_MM_ADDRESS !== h_addr || AVALON_MM_BURSTCOUNT !== h_bc
            || AVALON_MM_WRITEDATA !== h_data) begin
          miscompares++;
          $display("FAIL stall_hold: addr %h bc %0d want addr %h bc %0d",
                   AVALON_MM_ADDRESS, AVALON_MM_BURSTCOUNT, h_addr, h_bc);
        end
      end
      if (!AVALON_MM_WAITREQUEST) begin
        held = 1'b0;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_beat: got addr %h want no beat",
                   AVALON_MM_ADDRESS);
        end else begin
          e = exp_q.pop_front();
          if (AVALON_MM_ADDRESS !== e.addr || AVALON_MM_BURSTCOUNT !== e.bc
              || AVALON_MM_WRITEDATA !== e.data) begin
            miscompares++;
            $display("FAIL beat: got addr %h bc %0d data %h want addr %h bc %0d data %h",
                     AVALON_MM_ADDRESS, AVALON_MM_BURSTCOUNT,
                     AVALON_MM_WRITEDATA[31:0], e.addr, e.bc, e.data[31:0]);
          end
        end
        beats_total++;
        bib++;
        if (bib >= int'(AVALON_MM_BURSTCOUNT)) begin
          bib = 0;
          started = 1'b0;
          ack_q.push_back(cyc + 20);
        end
      end else begin
        held = 1'b1;
        h_addr = AVALON_MM_ADDRESS;
        h_bc = AVALON_MM_BURSTCOUNT;
        h_data = AVALON_MM_WRITEDATA;
      end
    end else begin
      held = 1'b0;
      if (bib != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL burst_gap: write dropped after %0d of %0d beats",
                 bib, AVALON_MM_BURSTCOUNT);
        bib = 0;
        started = 1'b0;
      end
    end
  end

  function automatic logic [511:0] word_of(input int seed, input int k);
    return {16{32'(seed + k)}};
  endfunction

  task automatic start_job(input logic [63:0] base, input int num);
    @(posedge CLK);
    #1;
    WRITE_REQ = 1'b1;
    WRITE_INITADDR = base;
    WRITE_NUM = 32'(num);
    job_base = base;
    job_num = num;
    @(posedge CLK);
    #1;
    WRITE_REQ = 1'b0;
  endtask

  task automatic feed(input int gap, input int seed);
    beat_t e;
    int b;
    int lastb;
    lastb = (job_num - 1) / 16;
    for (int k = 0; k < job_num; k++) begin
      bit ok;
      WRITE_DATA = word_of(seed, k);
      WRITE_DATAEN = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 1000 && !ok; t++) begin
        @(negedge CLK);
        ok = WRITE_DATA_RDY;
      end
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL feed_timeout: word %0d not accepted want accepted", k);
        WRITE_DATAEN = 1'b0;
        return;
      end
      @(posedge CLK);
      b = k / 16;
      e.addr = job_base + 64'(b) * 64'h400;
      e.bc = (b == lastb) ? ((job_num % 16 == 0) ? 5'd16 : 5'(job_num % 16))
                          : 5'd16;
      e.data = word_of(seed, k);
      exp_q.push_back(e);
      pushed_total++;
      #1;
      WRITE_DATAEN = 1'b0;
      repeat (gap) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge CLK);
      done = WRITE_RDY && exp_q.size() == 0;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_done: rdy %0b pending %0d want rdy 1 pending 0",
               name, WRITE_RDY, exp_q.size());
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({WRITE_RDY, WRITE_DATA_RDY, AVALON_MM_WRITE, AVALON_MM_READ} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 1000",
               {WRITE_RDY, WRITE_DATA_RDY, AVALON_MM_WRITE, AVALON_MM_READ});
    end
    vectors++;
    if (AVALON_MM_ADDRESS !== 64'h0 || AVALON_MM_BURSTCOUNT !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_addr_bc: got %h/%0d want 0/0",
               AVALON_MM_ADDRESS, AVALON_MM_BURSTCOUNT);
    end
    vectors++;
    if (AVALON_MM_BYTEENABLE !== {64{1'b1}}) begin
      miscompares++;
      $display("FAIL byteenable: got %h want all ones", AVALON_MM_BYTEENABLE);
    end
  endtask

  task automatic test_single_burst;
    int nb;
    nb = n_bursts;
    start_job(64'h0, 16);
    vectors++;
    if (WRITE_RDY !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy: rdy %0b want 0", WRITE_RDY);
    end
    feed(0, 1);
    wait_idle("single");
    vectors++;
    if (n_bursts - nb != 1) begin
      miscompares++;
      $display("FAIL single_bursts: got %0d want 1", n_bursts - nb);
    end
  endtask

  task automatic test_multi_burst(input bit stall);
    int nb;
    int sc;
    nb = n_bursts;
    sc = stall_checks;
    stall_en = stall;
    start_job(64'h1000, 35);
    feed(0, 100);
    wait_idle(stall ? "stall" : "multi");
    stall_en = 1'b0;
    vectors++;
    if (n_bursts - nb != 3) begin
      miscompares++;
      $display("FAIL multi_bursts: got %0d want 3", n_bursts - nb);
    end
    if (stall) begin
      vectors++;
      if (stall_checks == sc) begin
        miscompares++;
        $display("FAIL stall_seen: got 0 stalled cycles want >0");
      end
    end
  endtask

  task automatic test_slow_user;
    int nb;
    nb = n_bursts;
    start_job(64'h4000, 20);
    feed(3, 500);
    wait_idle("slow");
    vectors++;
    if (n_bursts - nb != 2) begin
      miscompares++;
      $display("FAIL slow_bursts: got %0d want 2", n_bursts - nb);
    end
  endtask

  task automatic test_ignored_and_reset;
    int b0;
    bit hit;
    @(posedge CLK);
    #1;
    WRITE_REQ = 1'b1;
    WRITE_INITADDR = 64'h7000;
    WRITE_NUM = '0;
    @(posedge CLK);
    #1;
    WRITE_REQ = 1'b0;
    @(negedge CLK);
    vectors++;
    if (WRITE_RDY !== 1'b1 || WRITE_DATA_RDY !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_num: rdy %0b drdy %0b want 1 0",
               WRITE_RDY, WRITE_DATA_RDY);
    end
    start_job(64'h2000, 16);
    @(posedge CLK);
    #1;
    WRITE_REQ = 1'b1;
    WRITE_INITADDR = 64'h9000;
    WRITE_NUM = 32'd5;
    @(posedge CLK);
    #1;
    WRITE_REQ = 1'b0;
    feed(0, 700);
    wait_idle("busy_req");

    start_job(64'h3000, 16);
    feed(0, 900);
    b0 = beats_total;
    hit = 1'b0;
    for (int t = 0; t < 500 && !hit; t++) begin
      @(negedge CLK);
      hit = (beats_total - b0 >= 7);
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    exp_q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    pushed_total = beats_total;
    b0 = beats_total;
    @(negedge CLK);
    vectors++;
    if (!hit || AVALON_MM_WRITE !== 1'b0 || WRITE_RDY !== 1'b1
        || WRITE_DATA_RDY !== 1'b0 || AVALON_MM_BURSTCOUNT !== 5'd0) begin
      miscompares++;
      $display("FAIL mid_reset: hit %0b wr %0b rdy %0b drdy %0b bc %0d want 1 0 1 0 0",
               hit, AVALON_MM_WRITE, WRITE_RDY, WRITE_DATA_RDY,
               AVALON_MM_BURSTCOUNT);
    end
    repeat (20) @(negedge CLK);
    vectors++;
    if (beats_total != b0) begin
      miscompares++;
      $display("FAIL post_reset_beats: got %0d want 0", beats_total - b0);
    end
    start_job(64'h5000, 3);
    feed(0, 1200);
    wait_idle("recover");
  endtask

`ifdef DRAM_WRITE_ACKWAIT_EN
  task automatic test_ackwait;
    int a0;
    bit up;
    repeat (30) @(posedge CLK);
    a0 = acks_sent;
    start_job(64'h8000, 48);
    feed(0, 2000);
    up = 1'b0;
    for (int t = 0; t < 800 && !up; t++) begin
      @(negedge CLK);
      up = WRITE_RDY;
    end
    vectors++;
    if (!up || acks_sent - a0 != 3 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ackwait: rdy %0b acks %0d want rdy 1 acks 3",
               up, acks_sent - a0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst(1'b0);
    test_multi_burst(1'b1);
    test_slow_user();
    test_ignored_and_reset();
`ifdef DRAM_WRITE_ACKWAIT_EN
    test_ackwait();
`endif
    repeat (5) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
